clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
- Mode and time-keeping controller for the refined clock.
- Takes the 1-cycle wrap tick from the prescaler counter and button pulses. It sequences the clock through RUN and three SET modes.
- Drives the prescaler's hold and clear controls and owns the hour/minute/second registers.
- Sits between the debounced button logic and the display formatter.

Parameters:
- RESET_HOUR, 0, hour value loaded on reset (0..23)
- RESET_MIN, 0, minute value loaded on reset (0..59)
- RESET_SEC, 0, second value loaded on reset (0..59)

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_tick  input  1  one-cycle pulse from the prescaler at its terminal count (1 Hz)
- i_mode_btn  input  1  one-cycle debounced pulse; advances the mode
- i_inc_btn  input  1  one-cycle debounced pulse; increments the selected field
- o_prescaler_hold  output  1  high = prescaler holds its count
- o_prescaler_clr  output  1  one-cycle pulse; prescaler returns to 0
- o_hour  output  5  hours, binary, 0..23
- o_min  output  6  minutes, binary, 0..59
- o_sec  output  6  seconds, binary, 0..59
- o_mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN, 3 = SET_SEC
- o_set_active  output  1  high in any SET mode, for display blink gating

Behaviour:
- Reset (async, i_rst high):
  - mode = RUN
  - time = RESET_HOUR:RESET_MIN:RESET_SEC
  - o_prescaler_hold = 0, o_prescaler_clr = 0
  - Reset mid-operation aborts any SET mode immediately.
- Output timing:
  - All outputs are registered.
  - Every event takes effect on the clock edge where its pulse is sampled, so it is visible one cycle later.
- FSM:
  - RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN, one step per i_mode_btn pulse.
  - No other transitions.
- RUN:
  - i_tick increments seconds.
  - 59 -> 0 carries into minutes; minute 59 -> 0 carries into hours; 23 -> 0.
  - 23:59:59 + tick = 00:00:00 in the same edge.
  - i_inc_btn is ignored.
- SET_x:
  - i_tick is ignored.
  - i_inc_btn increments only the selected field, with wrap at its limit and no carry.
  - Hour wraps 23 -> 0; minute and second wrap 59 -> 0.
- Prescaler hold: o_prescaler_hold = 1 in every SET mode, 0 in RUN; it is registered with the mode.
- Prescaler clear: o_prescaler_clr pulses for exactly one cycle on the SET_SEC -> RUN transition, so the first second after setting is full length.
- Simultaneous events:
  - RUN with i_tick and i_mode_btn: the tick is applied and the mode moves to SET_HOUR.
  - SET with i_mode_btn and i_inc_btn: the mode advances and the increment is dropped.
  - SET_SEC with i_mode_btn and i_tick: the tick is dropped, the mode goes to RUN, and clr pulses.
- Out-of-range parameter values are clipped to 0 at elaboration, with an error message.

Optional Feature:
- Macro: CLOCK_MODE_CTRL_DEC_EN
- Defined:
  - Adds port i_dec_btn (input, 1).
  - In SET modes it decrements the selected field with wrap (0 -> 23 or 0 -> 59) and no borrow.
  - With both i_inc_btn and i_dec_btn in one cycle, neither is applied.
  - In RUN, i_dec_btn is ignored.
  - If i_mode_btn arrives in the same cycle, mode wins and i_dec_btn is dropped.
- Undefined: no i_dec_btn port; the block is increment-only.

Decomposition:
- Shared package clock_pkg:
  - mode encoding constants MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC
  - field widths HOUR_W = 5, MIN_W = 6, SEC_W = 6
  - limits HOUR_LAST = 23, MIN_LAST = 59, SEC_LAST = 59
- One sub-module, wrap_field_counter:
  - Parameterized width and last value; inputs inc, dec (optional), load.
  - Output carry asserts when incrementing at the last value.
  - Instanced three times, with seconds' carry feeding minutes' inc and minutes' carry feeding hours' inc in RUN only.

Test Plan:
1. Reset with RESET_HOUR = 12 -> o_hour = 12, o_min = 0, o_sec = 0, o_mode = 0, hold = 0, clr = 0.
2. Preload 23:59:58, two i_tick pulses -> 23:59:59 then 00:00:00; no glitch on o_mode.
3. Mode pulse ×1 -> o_mode = 1, hold = 1. Inc ×25 -> o_hour advances by 25 mod 24 = 1 from its start, minutes unchanged. i_tick during SET -> no change.
4. SET_SEC at sec = 59: inc -> 0 with o_min unchanged. Then mode -> o_mode = 0, hold = 0, clr high exactly one cycle.
5. RUN with i_tick and i_mode_btn in the same cycle -> sec +1 and o_mode = 1. In SET_MIN, mode and inc together -> o_mode = 3, minutes unchanged.
6. CLOCK_MODE_CTRL_DEC_EN build:
   - SET_HOUR at 0, dec -> 23.
   - inc and dec together -> unchanged.
   - Assert i_rst mid-SET -> RUN with reset time on the same edge.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared encodings, field widths and wrap limits for the clock mode/time-keeping logic.
package clock_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam int unsigned HOUR_LAST = 23;
  localparam int unsigned MIN_LAST  = 59;
  localparam int unsigned SEC_LAST  = 59;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN      = 2'd0;
  localparam mode_t MODE_SET_HOUR = 2'd1;
  localparam mode_t MODE_SET_MIN  = 2'd2;
  localparam mode_t MODE_SET_SEC  = 2'd3;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      MODE_RUN:      n = MODE_SET_HOUR;
      MODE_SET_HOUR: n = MODE_SET_MIN;
      MODE_SET_MIN:  n = MODE_SET_SEC;
      default:       n = MODE_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/wrap_field_counter.sv
// Modulo (Last+1) up/down counter for one time field; carry flags an increment at Last.
module wrap_field_counter #(
  parameter int unsigned Width    = 6,
  parameter int unsigned Last     = 59,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] value_o,
  output logic             carry_o
);

  localparam logic [Width-1:0] LastV = Width'(Last);

  logic [Width-1:0] value_q, value_d;
  logic             inc_only, dec_only;

  // Opposing requests in the same cycle cancel.
  assign inc_only = inc_i & ~dec_i;
  assign dec_only = dec_i & ~inc_i;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (inc_only) begin
      value_d = (value_q == LastV) ? '0 : value_q + 1'b1;
    end else if (dec_only) begin
      value_d = (value_q == '0) ? LastV : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= ResetVal;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = inc_only & ~load_i & (value_q == LastV);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer and hh:mm:ss keeper; optional decrement button under CLOCK_MODE_CTRL_DEC_EN.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RESET_HOUR = 0,
  parameter int unsigned RESET_MIN  = 0,
  parameter int unsigned RESET_SEC  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_mode_btn,
  input  logic              i_inc_btn,
`ifdef CLOCK_MODE_CTRL_DEC_EN
  input  logic              i_dec_btn,
`endif
  output logic              o_prescaler_hold,
  output logic              o_prescaler_clr,
  output logic [HOUR_W-1:0] o_hour,
  output logic [MIN_W-1:0]  o_min,
  output logic [SEC_W-1:0]  o_sec,
  output logic [1:0]        o_mode,
  output logic              o_set_active
);

  localparam int unsigned HourInit = (RESET_HOUR <= HOUR_LAST) ? RESET_HOUR : 0;
  localparam int unsigned MinInit  = (RESET_MIN <= MIN_LAST) ? RESET_MIN : 0;
  localparam int unsigned SecInit  = (RESET_SEC <= SEC_LAST) ? RESET_SEC : 0;

  if (RESET_HOUR > HOUR_LAST) begin : g_bad_hour
    $error("clock_mode_ctrl: RESET_HOUR out of range, clipped to 0");
  end
  if (RESET_MIN > MIN_LAST) begin : g_bad_min
    $error("clock_mode_ctrl: RESET_MIN out of range, clipped to 0");
  end
  if (RESET_SEC > SEC_LAST) begin : g_bad_sec
    $error("clock_mode_ctrl: RESET_SEC out of range, clipped to 0");
  end

  mode_t mode_q, mode_d;
  logic  hold_q, hold_d;
  logic  clr_q, clr_d;

  logic dec_btn;
`ifdef CLOCK_MODE_CTRL_DEC_EN
  assign dec_btn = i_dec_btn;
`else
  assign dec_btn = 1'b0;
`endif

  logic in_run, run_tick, edit_ok, inc_edit, dec_edit;
  logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic sec_carry, min_carry, hour_carry;

  assign in_run   = (mode_q == MODE_RUN);
  // A tick in RUN is applied even when the mode button moves us to SET_HOUR.
  assign run_tick = in_run & i_tick;
  // Edits are dropped on a mode step or when inc and dec collide.
  assign edit_ok  = ~in_run & ~i_mode_btn & ~(i_inc_btn & dec_btn);
  assign inc_edit = edit_ok & i_inc_btn;
  assign dec_edit = edit_ok & dec_btn;

  assign sec_inc  = run_tick | ((mode_q == MODE_SET_SEC) & inc_edit);
  assign sec_dec  = (mode_q == MODE_SET_SEC) & dec_edit;
  assign min_inc  = (run_tick & sec_carry) | ((mode_q == MODE_SET_MIN) & inc_edit);
  assign min_dec  = (mode_q == MODE_SET_MIN) & dec_edit;
  assign hour_inc = (run_tick & min_carry) | ((mode_q == MODE_SET_HOUR) & inc_edit);
  assign hour_dec = (mode_q == MODE_SET_HOUR) & dec_edit;

  always_comb begin
    mode_d = mode_q;
    clr_d  = 1'b0;
    if (i_mode_btn) begin
      mode_d = next_mode(mode_q);
      clr_d  = (mode_q == MODE_SET_SEC);
    end
    hold_d = (mode_d != MODE_RUN);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q <= MODE_RUN;
      hold_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      hold_q <= hold_d;
      clr_q  <= clr_d;
    end
  end

  wrap_field_counter #(
    .Width    (SEC_W),
    .Last     (SEC_LAST),
    .ResetVal (SEC_W'(SecInit))
  ) u_sec (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .inc_i      (sec_inc),
    .dec_i      (sec_dec),
    .load_i     (1'b0),
    .load_val_i ('0),
    .value_o    (o_sec),
    .carry_o    (sec_carry)
  );

  wrap_field_counter #(
    .Width    (MIN_W),
    .Last     (MIN_LAST),
    .ResetVal (MIN_W'(MinInit))
  ) u_min (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .inc_i      (min_inc),
    .dec_i      (min_dec),
    .load_i     (1'b0),
    .load_val_i ('0),
    .value_o    (o_min),
    .carry_o    (min_carry)
  );

  wrap_field_counter #(
    .Width    (HOUR_W),
    .Last     (HOUR_LAST),
    .ResetVal (HOUR_W'(HourInit))
  ) u_hour (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .inc_i      (hour_inc),
    .dec_i      (hour_dec),
    .load_i     (1'b0),
    .load_val_i ('0),
    .value_o    (o_hour),
    .carry_o    (hour_carry)
  );

  logic unused_carry;
  assign unused_carry = hour_carry;

  assign o_mode           = mode_q;
  assign o_prescaler_hold = hold_q;
  assign o_set_active     = hold_q;
  assign o_prescaler_clr  = clr_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: vector table plus multi-cycle corner sequences.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, mode_btn, inc_btn, dec_btn;
  logic       hold, clr, set_active;
  logic [4:0] hour;
  logic [5:0] minute, sec;
  logic [1:0] mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .RESET_HOUR (12),
    .RESET_MIN  (0),
    .RESET_SEC  (0)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_tick           (tick),
    .i_mode_btn       (mode_btn),
    .i_inc_btn        (inc_btn),
`ifdef CLOCK_MODE_CTRL_DEC_EN
    .i_dec_btn        (dec_btn),
`endif
    .o_prescaler_hold (hold),
    .o_prescaler_clr  (clr),
    .o_hour           (hour),
    .o_min            (minute),
    .o_sec            (sec),
    .o_mode           (mode),
    .o_set_active     (set_active)
  );

  typedef struct {
    logic t, m, i, d;
    int   h, mi, s, md, hd, cl;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int h, input int mi, input int s,
                              input int md, input int hd, input int cl);
    chk({tag, ".hour"}, 32'(hour), h);
    chk({tag, ".min"}, 32'(minute), mi);
    chk({tag, ".sec"}, 32'(sec), s);
    chk({tag, ".mode"}, 32'(mode), md);
    chk({tag, ".hold"}, 32'(hold), hd);
    chk({tag, ".set_active"}, 32'(set_active), hd);
    chk({tag, ".clr"}, 32'(clr), cl);
  endtask

  // Hold inputs for exactly one sampling edge, then look at outputs 1ns later.
  task automatic step(input logic t, input logic m, input logic i, input logic d);
    tick = t; mode_btn = m; inc_btn = i; dec_btn = d;
    @(posedge clk);
    #1;
    tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
  endtask

  initial begin
    //            t  m  i  d   h  mi  s md hd cl
    vecs[0]  = '{1, 0, 0, 0, 12, 0, 1, 0, 0, 0};  // tick in RUN
    vecs[1]  = '{0, 0, 1, 0, 12, 0, 1, 0, 0, 0};  // inc ignored in RUN
    vecs[2]  = '{1, 1, 0, 0, 12, 0, 2, 1, 1, 0};  // tick applied, mode advances
    vecs[3]  = '{1, 0, 0, 0, 12, 0, 2, 1, 1, 0};  // tick ignored in SET
    vecs[4]  = '{0, 0, 1, 0, 13, 0, 2, 1, 1, 0};
    vecs[5]  = '{0, 1, 1, 0, 13, 0, 2, 2, 1, 0};  // mode wins over inc
    vecs[6]  = '{0, 0, 1, 0, 13, 1, 2, 2, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 13, 1, 2, 3, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 13, 1, 3, 3, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 13, 1, 3, 0, 0, 1};  // tick dropped, clr pulses
    vecs[10] = '{0, 0, 0, 0, 13, 1, 3, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 13, 1, 4, 0, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 13, 1, 4, 1, 1, 0};
    vecs[13] = '{0, 1, 0, 0, 13, 1, 4, 2, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 13, 1, 4, 3, 1, 0};
    vecs[15] = '{0, 1, 0, 0, 13, 1, 4, 0, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 13, 1, 4, 0, 0, 0};
    vecs[17] = '{0, 0, 0, 1, 13, 1, 4, 0, 0, 0};  // dec ignored in RUN

    rst = 1'b1; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    #12;
    expect_state("reset", 12, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_state("post_reset", 12, 0, 0, 0, 0, 0);

    for (int k = 0; k < 18; k++) begin
      step(vecs[k].t, vecs[k].m, vecs[k].i, vecs[k].d);
      expect_state($sformatf("vec%0d", k), vecs[k].h, vecs[k].mi, vecs[k].s,
                   vecs[k].md, vecs[k].hd, vecs[k].cl);
    end

    // SET_HOUR: 25 increments from 13 land on 14; ticks do nothing.
    step(0, 1, 0, 0);
    for (int k = 0; k < 25; k++) step(0, 0, 1, 0);
    expect_state("inc25", 14, 1, 4, 1, 1, 0);
    step(1, 0, 0, 0);
    expect_state("set_tick", 14, 1, 4, 1, 1, 0);

    // Walk to 23:59:58 and roll over through RUN ticks.
    for (int k = 0; k < 9; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 58; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 54; k++) step(0, 0, 1, 0);
    expect_state("preload", 23, 59, 58, 3, 1, 0);
    step(0, 1, 0, 0);
    expect_state("to_run", 23, 59, 58, 0, 0, 1);
    step(1, 0, 0, 0);
    expect_state("tick59", 23, 59, 59, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_state("midnight", 0, 0, 0, 0, 0, 0);

    // SET_SEC wrap without carry; SET_MIN mode+inc drops the inc.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    expect_state("min_mode_inc", 0, 0, 0, 3, 1, 0);
    for (int k = 0; k < 59; k++) step(0, 0, 1, 0);
    expect_state("sec59", 0, 0, 59, 3, 1, 0);
    step(0, 0, 1, 0);
    expect_state("sec_wrap", 0, 0, 0, 3, 1, 0);
    step(0, 1, 0, 0);
    expect_state("clr_hi", 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    expect_state("clr_lo", 0, 0, 0, 0, 0, 0);

`ifdef CLOCK_MODE_CTRL_DEC_EN
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    expect_state("dec_hour", 23, 0, 0, 1, 1, 0);
    step(0, 0, 1, 1);
    expect_state("inc_dec", 23, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1);
    expect_state("mode_dec", 23, 0, 0, 2, 1, 0);
    step(0, 0, 0, 1);
    expect_state("dec_min", 23, 59, 0, 2, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    expect_state("dec_sec", 23, 59, 59, 3, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    expect_state("pre_rst", 23, 59, 59, 1, 1, 0);
`else
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    expect_state("pre_rst", 1, 0, 0, 1, 1, 0);
`endif

    // Asynchronous reset in the middle of a SET mode.
    #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 12, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_state("after_rst", 12, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
